frame_buffer_controller: RTL and testbench

- Sequences the single-port `frame_buffer` (P_ROWS-row circular line store) between the incoming grayscale pixel stream and the downstream edge-detection window logic.
- Writes incoming pixels row by row. Once three complete rows are held, it stops accepting pixels, reads back every column of the three newest rows, and emits one vertical 3-pixel column per column index.
- It is the only master of the buffer's row, column, pixel, write-enable and read-enable inputs, and guarantees that read and write are never enabled in the same cycle.

---
 rtl/frame_buffer_controller.sv | 215 +++++++++++++++++++++
 tb/tb_frame_buffer_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_controller.sv
// Write/read sequencer for a single-port circular line store: fills rows from the
// pixel stream, then reads back the three newest rows as vertical 3-pixel columns.
module frame_buffer_controller #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 4,
    parameter int P_PIXEL_DEPTH = 8
) (
    input  logic                         I_CLK,
    input  logic                         I_RESET,
    input  logic                         I_FRAME_RESTART,
    input  logic [P_PIXEL_DEPTH-1:0]     I_PIXEL,
    input  logic                         I_PIXEL_VALID,
    output logic                         O_PIXEL_READY,
    output logic [$clog2(P_COLUMNS)-1:0] O_BUF_COLUMN,
    output logic [$clog2(P_ROWS)-1:0]    O_BUF_ROW,
    output logic [P_PIXEL_DEPTH-1:0]     O_BUF_PIXEL,
    output logic                         O_BUF_WRITE_ENABLE,
    output logic                         O_BUF_READ_ENABLE,
    input  logic [P_PIXEL_DEPTH-1:0]     I_BUF_PIXEL,
    output logic [P_PIXEL_DEPTH-1:0]     O_COLUMN_TOP,
    output logic [P_PIXEL_DEPTH-1:0]     O_COLUMN_MID,
    output logic [P_PIXEL_DEPTH-1:0]     O_COLUMN_BOT,
    output logic [$clog2(P_COLUMNS)-1:0] O_COLUMN_INDEX,
    output logic                         O_COLUMN_VALID,
    output logic                         O_BUSY
);

    localparam int COL_W = $clog2(P_COLUMNS);
    localparam int ROW_W = $clog2(P_ROWS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(P_COLUMNS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(P_ROWS - 1);

    typedef enum logic [1:0] {
        ST_WRITE = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ROW_W-1:0]       wr_row_q, wr_row_d;
    logic [COL_W-1:0]       wr_col_q, wr_col_d;
    logic [1:0]             rows_filled_q, rows_filled_d;
    logic [COL_W-1:0]       rd_col_q, rd_col_d;
    logic [1:0]             rd_phase_q, rd_phase_d;
    logic                   pixel_ready_q, pixel_ready_d;
    logic                   busy_q, busy_d;
    logic                   pipe_valid_q, pipe_valid_d;
    logic [1:0]             pipe_phase_q, pipe_phase_d;
    logic [COL_W-1:0]       pipe_col_q, pipe_col_d;
    logic [P_PIXEL_DEPTH-1:0] top_hold_q, top_hold_d;
    logic [P_PIXEL_DEPTH-1:0] mid_hold_q, mid_hold_d;
    logic [P_PIXEL_DEPTH-1:0] col_top_q, col_top_d;
    logic [P_PIXEL_DEPTH-1:0] col_mid_q, col_mid_d;
    logic [P_PIXEL_DEPTH-1:0] col_bot_q, col_bot_d;
    logic [COL_W-1:0]       col_index_q, col_index_d;
    logic                   col_valid_q, col_valid_d;

    logic                   clear;
    logic                   accept;
    logic [ROW_W-1:0]       row_top, row_mid, row_bot, rd_row;

    // Steps back k rows around the circular store; valid for any P_ROWS >= 4.
    function automatic logic [ROW_W-1:0] row_back(input logic [ROW_W-1:0] base, input int k);
        int t;
        t = int'(base) - k;
        if (t < 0) begin
            t = t + P_ROWS;
        end
        return ROW_W'(t);
    endfunction

    assign clear  = I_RESET | I_FRAME_RESTART;
    assign accept = I_PIXEL_VALID & pixel_ready_q;

    // wr_row already points at the next row to be written, so the newest row is one behind.
    assign row_top = row_back(wr_row_q, 3);
    assign row_mid = row_back(wr_row_q, 2);
    assign row_bot = row_back(wr_row_q, 1);

    always_comb begin
        rd_row = row_bot;
        case (rd_phase_q)
            2'd0:    rd_row = row_top;
            2'd1:    rd_row = row_mid;
            default: rd_row = row_bot;
        endcase
    end

    assign O_BUF_PIXEL        = I_PIXEL;
    assign O_BUF_WRITE_ENABLE = accept;
    assign O_BUF_READ_ENABLE  = (state_q == ST_READ);
    assign O_BUF_ROW          = (state_q == ST_READ) ? rd_row : wr_row_q;
    assign O_BUF_COLUMN       = (state_q == ST_READ) ? rd_col_q : wr_col_q;

    always_comb begin
        state_d       = state_q;
        wr_row_d      = wr_row_q;
        wr_col_d      = wr_col_q;
        rows_filled_d = rows_filled_q;
        rd_col_d      = rd_col_q;
        rd_phase_d    = rd_phase_q;
        top_hold_d    = top_hold_q;
        mid_hold_d    = mid_hold_q;
        col_top_d     = col_top_q;
        col_mid_d     = col_mid_q;
        col_bot_d     = col_bot_q;
        col_index_d   = col_index_q;
        col_valid_d   = 1'b0;
        pipe_valid_d  = (state_q == ST_READ);
        pipe_phase_d  = rd_phase_q;
        pipe_col_d    = rd_col_q;

        case (state_q)
            ST_WRITE: begin
                if (accept) begin
                    if (wr_col_q == LAST_COL) begin
                        wr_col_d      = '0;
                        wr_row_d      = (wr_row_q == LAST_ROW) ? '0 : wr_row_q + 1'b1;
                        rows_filled_d = (rows_filled_q == 2'd3) ? 2'd3 : rows_filled_q + 2'd1;
                        if (rows_filled_d == 2'd3) begin
                            state_d = ST_READ;
                        end
                    end else begin
                        wr_col_d = wr_col_q + 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (rd_phase_q == 2'd2) begin
                    rd_phase_d = 2'd0;
                    if (rd_col_q == LAST_COL) begin
                        rd_col_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        rd_col_d = rd_col_q + 1'b1;
                    end
                end else begin
                    rd_phase_d = rd_phase_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_WRITE;
            end
        endcase

        // I_BUF_PIXEL carries the read issued last cycle, tagged by the pipe registers.
        if (pipe_valid_q) begin
            case (pipe_phase_q)
                2'd0: top_hold_d = I_BUF_PIXEL;
                2'd1: mid_hold_d = I_BUF_PIXEL;
                default: begin
                    col_top_d   = top_hold_q;
                    col_mid_d   = mid_hold_q;
                    col_bot_d   = I_BUF_PIXEL;
                    col_index_d = pipe_col_q;
                    col_valid_d = 1'b1;
                end
            endcase
        end
    end

    assign pixel_ready_d = (state_d == ST_WRITE);
    assign busy_d        = (state_d != ST_WRITE);

    always_ff @(posedge I_CLK) begin
        if (clear) begin
            state_q       <= ST_WRITE;
            wr_row_q      <= '0;
            wr_col_q      <= '0;
            rows_filled_q <= '0;
            rd_col_q      <= '0;
            rd_phase_q    <= '0;
            pixel_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            pipe_valid_q  <= 1'b0;
            pipe_phase_q  <= '0;
            pipe_col_q    <= '0;
            top_hold_q    <= '0;
            mid_hold_q    <= '0;
            col_top_q     <= '0;
            col_mid_q     <= '0;
            col_bot_q     <= '0;
            col_index_q   <= '0;
            col_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_row_q      <= wr_row_d;
            wr_col_q      <= wr_col_d;
            rows_filled_q <= rows_filled_d;
            rd_col_q      <= rd_col_d;
            rd_phase_q    <= rd_phase_d;
            pixel_ready_q <= pixel_ready_d;
            busy_q        <= busy_d;
            pipe_valid_q  <= pipe_valid_d;
            pipe_phase_q  <= pipe_phase_d;
            pipe_col_q    <= pipe_col_d;
            top_hold_q    <= top_hold_d;
            mid_hold_q    <= mid_hold_d;
            col_top_q     <= col_top_d;
            col_mid_q     <= col_mid_d;
            col_bot_q     <= col_bot_d;
            col_index_q   <= col_index_d;
            col_valid_q   <= col_valid_d;
        end
    end

    assign O_PIXEL_READY  = pixel_ready_q;
    assign O_BUSY         = busy_q;
    assign O_COLUMN_TOP   = col_top_q;
    assign O_COLUMN_MID   = col_mid_q;
    assign O_COLUMN_BOT   = col_bot_q;
    assign O_COLUMN_INDEX = col_index_q;
    assign O_COLUMN_VALID = col_valid_q;

endmodule

// File: tb/tb_frame_buffer_controller.sv
// Directed bench: two controllers (4-row and 5-row stores, 4 columns) share one pixel
// stream, each backed by a behavioural registered-read line store.
module tb_frame_buffer_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic [7:0] pix = 8'h00;
    logic       pv = 1'b0;

    logic       a_ready, a_we, a_re, a_valid, a_busy;
    logic [1:0] a_col, a_row, a_idx;
    logic [7:0] a_bpix, a_rdata, a_top, a_mid, a_bot;

    logic       b_ready, b_we, b_re, b_valid, b_busy;
    logic [1:0] b_col, b_idx;
    logic [2:0] b_row;
    logic [7:0] b_bpix, b_rdata, b_top, b_mid, b_bot;

    frame_buffer_controller #(.P_COLUMNS(4), .P_ROWS(4), .P_PIXEL_DEPTH(8)) dut_a (
        .I_CLK(clk), .I_RESET(rst), .I_FRAME_RESTART(restart),
        .I_PIXEL(pix), .I_PIXEL_VALID(pv), .O_PIXEL_READY(a_ready),
        .O_BUF_COLUMN(a_col), .O_BUF_ROW(a_row), .O_BUF_PIXEL(a_bpix),
        .O_BUF_WRITE_ENABLE(a_we), .O_BUF_READ_ENABLE(a_re), .I_BUF_PIXEL(a_rdata),
        .O_COLUMN_TOP(a_top), .O_COLUMN_MID(a_mid), .O_COLUMN_BOT(a_bot),
        .O_COLUMN_INDEX(a_idx), .O_COLUMN_VALID(a_valid), .O_BUSY(a_busy)
    );

    frame_buffer_controller #(.P_COLUMNS(4), .P_ROWS(5), .P_PIXEL_DEPTH(8)) dut_b (
        .I_CLK(clk), .I_RESET(rst), .I_FRAME_RESTART(restart),
        .I_PIXEL(pix), .I_PIXEL_VALID(pv), .O_PIXEL_READY(b_ready),
        .O_BUF_COLUMN(b_col), .O_BUF_ROW(b_row), .O_BUF_PIXEL(b_bpix),
        .O_BUF_WRITE_ENABLE(b_we), .O_BUF_READ_ENABLE(b_re), .I_BUF_PIXEL(b_rdata),
        .O_COLUMN_TOP(b_top), .O_COLUMN_MID(b_mid), .O_COLUMN_BOT(b_bot),
        .O_COLUMN_INDEX(b_idx), .O_COLUMN_VALID(b_valid), .O_BUSY(b_busy)
    );

    logic [7:0] mem_a [4][4];
    logic [7:0] mem_b [5][4];

    always @(posedge clk) begin
        if (a_we) mem_a[a_row][a_col] <= a_bpix;
        if (a_re) a_rdata <= mem_a[a_row][a_col];
        if (b_we) mem_b[b_row][b_col] <= b_bpix;
        if (b_re) b_rdata <= mem_b[b_row][b_col];
    end

    typedef struct {
        logic [7:0] t, m, b;
        logic [1:0] idx;
        int         cyc;
        logic       rdy;
    } pulse_t;

    pulse_t     qa[$];
    pulse_t     qb[$];
    logic [2:0] rowq_a[$];
    logic [2:0] rowq_b[$];
    int         cyc = 0;
    bit         excl_bad = 1'b0;
    int         assertions = 0;
    int         failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_valid) qa.push_back('{a_top, a_mid, a_bot, a_idx, cyc, a_ready});
        if (b_valid) qb.push_back('{b_top, b_mid, b_bot, b_idx, cyc, b_ready});
        if (a_re) rowq_a.push_back({1'b0, a_row});
        if (b_re) rowq_b.push_back(b_row);
        if ((a_we && a_re) || (b_we && b_re)) excl_bad = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic clear_queues();
        qa.delete(); qb.delete(); rowq_a.delete(); rowq_b.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_queues();
    endtask

    // Called on a negedge; returns on the negedge after the pixel was accepted.
    task automatic send(input logic [7:0] p);
        int n;
        n = 0;
        pix = p; pv = 1'b1;
        while (!a_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        assertions++;
        if (!a_ready) begin
            failures++;
            $display("FAIL send_ready_timeout: ready=%0b pixel=%02h, required ready=1 within 100 cycles", a_ready, p);
        end
        @(negedge clk);
    endtask

    task automatic stream(input logic [7:0] first, input int count, input bit gaps);
        for (int k = 0; k < count; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                pv = 1'b0; pix = 8'hEE;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send(first + 8'(k));
        end
        pv = 1'b0;
    endtask

    task automatic wait_pulses(input string name, input int n);
        int k;
        k = 0;
        while ((qa.size() < n || qb.size() < n) && k < 80) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        assertions++;
        if (qa.size() != n || qb.size() != n) begin
            failures++;
            $display("FAIL %s_pulse_count: got a=%0d b=%0d, required %0d", name, qa.size(), qb.size(), n);
        end
    endtask

    // Readout of rows holding base, base+4, base+8 (column c adds c).
    task automatic check_readout(input string name, input logic [7:0] base);
        logic [7:0] et, em, eb;
        wait_pulses(name, 4);
        for (int c = 0; c < 4 && c < qa.size() && c < qb.size(); c++) begin
            et = base + 8'(c); em = base + 8'(4 + c); eb = base + 8'(8 + c);
            assertions++;
            if ({qa[c].t, qa[c].m, qa[c].b, qa[c].idx} !== {et, em, eb, 2'(c)}) begin
                failures++;
                $display("FAIL %s_a_col%0d: got (%02h,%02h,%02h) idx %0d, required (%02h,%02h,%02h) idx %0d",
                         name, c, qa[c].t, qa[c].m, qa[c].b, qa[c].idx, et, em, eb, c);
            end
            assertions++;
            if ({qb[c].t, qb[c].m, qb[c].b, qb[c].idx} !== {et, em, eb, 2'(c)}) begin
                failures++;
                $display("FAIL %s_b_col%0d: got (%02h,%02h,%02h) idx %0d, required (%02h,%02h,%02h) idx %0d",
                         name, c, qb[c].t, qb[c].m, qb[c].b, qb[c].idx, et, em, eb, c);
            end
            if (c > 0) begin
                assertions++;
                if (qa[c].cyc - qa[c-1].cyc != 3) begin
                    failures++;
                    $display("FAIL %s_spacing%0d: got %0d cycles, required 3", name, c, qa[c].cyc - qa[c-1].cyc);
                end
            end
            assertions++;
            if (qa[c].rdy !== (c == 3)) begin
                failures++;
                $display("FAIL %s_ready_at_col%0d: got %0b, required %0b", name, c, qa[c].rdy, (c == 3));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; pv = 1'b0;
        repeat (2) @(negedge clk);
        assertions++;
        if ({a_ready, a_we, a_re, a_valid, a_busy, a_top} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%0b we=%0b re=%0b vld=%0b busy=%0b top=%02h, required all 0",
                     a_ready, a_we, a_re, a_valid, a_busy, a_top);
        end
        rst = 1'b0;
        @(negedge clk);
        assertions++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got ready a=%0b b=%0b busy=%0b, required ready 1 busy 0", a_ready, b_ready, a_busy);
        end
        clear_queues();
    endtask

    task automatic test_first_readout();
        int entry;
        stream(8'h00, 12, 1'b0);
        entry = cyc;
        assertions++;
        if (a_ready !== 1'b0 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL first_enter_read: got ready=%0b busy=%0b, required ready=0 busy=1", a_ready, a_busy);
        end
        check_readout("first", 8'h00);
        assertions++;
        if (qa.size() == 0 || qa[0].cyc - entry != 4) begin
            failures++;
            $display("FAIL first_latency: got %0d cycles after READ entry, required 4",
                     (qa.size() == 0) ? -1 : qa[0].cyc - entry);
        end
        clear_queues();
    endtask

    task automatic test_sliding();
        stream(8'h0C, 4, 1'b0);
        check_readout("slide1", 8'h04);
        clear_queues();
        stream(8'h10, 4, 1'b0);
        check_readout("slide2", 8'h08);
        clear_queues();
    endtask

    task automatic test_non_pow2();
        stream(8'h14, 4, 1'b0);
        check_readout("rows6", 8'h0C);
        assertions++;
        if (rowq_b.size() != 12 || rowq_b[0] !== 3'd3 || rowq_b[1] !== 3'd4 || rowq_b[2] !== 3'd0) begin
            failures++;
            $display("FAIL rows6_b_rows: got %0d reads first rows %0d,%0d,%0d, required 12 reads rows 3,4,0",
                     rowq_b.size(), rowq_b[0], rowq_b[1], rowq_b[2]);
        end
        assertions++;
        if (rowq_a.size() != 12 || rowq_a[0] !== 3'd3 || rowq_a[1] !== 3'd0 || rowq_a[2] !== 3'd1) begin
            failures++;
            $display("FAIL rows6_a_rows: got %0d reads first rows %0d,%0d,%0d, required 12 reads rows 3,0,1",
                     rowq_a.size(), rowq_a[0], rowq_a[1], rowq_a[2]);
        end
        clear_queues();
    endtask

    task automatic test_gapped();
        do_reset();
        stream(8'h00, 12, 1'b1);
        check_readout("gapped", 8'h00);
        assertions++;
        if (excl_bad) begin
            failures++;
            $display("FAIL gapped_exclusive: got write and read enable both high, required never");
        end
        clear_queues();
    endtask

    task automatic test_restart();
        do_reset();
        stream(8'h40, 6, 1'b0);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        stream(8'h20, 11, 1'b0);
        assertions++;
        if (qa.size() != 0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
            failures++;
            $display("FAIL restart_no_early_read: got pulses=%0d busy=%0b ready=%0b, required 0 pulses busy 0 ready 1",
                     qa.size(), a_busy, a_ready);
        end
        stream(8'h2B, 1, 1'b0);
        check_readout("restart", 8'h20);
        clear_queues();
    endtask

    task automatic test_reset_mid_read();
        int n0;
        stream(8'h2C, 4, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n0 = qa.size();
        assertions++;
        if (a_ready !== 1'b0 || a_re !== 1'b0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL midread_reset_state: got ready=%0b re=%0b busy=%0b, required 0,0,0", a_ready, a_re, a_busy);
        end
        @(negedge clk);
        assertions++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL midread_ready: got %0b, required 1", a_ready);
        end
        repeat (20) @(negedge clk);
        assertions++;
        if (qa.size() != n0) begin
            failures++;
            $display("FAIL midread_no_pulses: got %0d pulses after reset, required 0", qa.size() - n0);
        end
    endtask

    initial begin
        test_reset();
        test_first_readout();
        test_sliding();
        test_non_pow2();
        test_gapped();
        test_restart();
        test_reset_mid_read();
        assertions++;
        if (excl_bad) begin
            failures++;
            $display("FAIL exclusive_enables: got write and read enable both high, required never");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
